// File: rtl/pipeline_pkg.sv
// +----------------------------------------------------------------------------+
// | pipeline_pkg: widths, reset defaults and the fetch state encoding shared   |
// | by the front-end pipeline stages.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
// +----------------------------------------------------------------------------+
// | if_id_register: pipeline register holding {pc_next, instruction, valid}    |
// | with load, hold and bubble insertion; bubble wins over load.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_id_register
  import pipeline_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [ADDR_W-1:0]  pc_next_i,
  input  logic [INSTR_W-1:0] instruction_i,
  output logic [ADDR_W-1:0]  pc_next_o,
  output logic [INSTR_W-1:0] instruction_o,
  output logic               valid_o
);

  logic [ADDR_W-1:0]  pc_next_q;
  logic [INSTR_W-1:0] instruction_q;
  logic               valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_next_q     <= '0;
      instruction_q <= NOP_INSTR;
      valid_q       <= 1'b0;
    end else if (bubble_i) begin
      pc_next_q     <= '0;
      instruction_q <= NOP_INSTR;
      valid_q       <= 1'b0;
    end else if (load_i) begin
      pc_next_q     <= pc_next_i;
      instruction_q <= instruction_i;
      valid_q       <= 1'b1;
    end
  end

  assign pc_next_o     = pc_next_q;
  assign instruction_o = instruction_q;
  assign valid_o       = valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +----------------------------------------------------------------------------+
// | fetch_stage: IF stage -- PC register, variable-latency imem handshake,     |
// | stall hold buffer, redirect drain and the IF/ID register.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_stall,
  input  logic               if_id_stall,
  input  logic               flush,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  pc_decode,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  if_id_pc_next,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic               if_id_valid,
  output logic               fetch_busy
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic [ADDR_W-1:0]  hold_pc_next_q, hold_pc_next_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

  logic               ifid_load;
  logic               ifid_bubble;
  logic [ADDR_W-1:0]  ifid_pc_next;
  logic [INSTR_W-1:0] ifid_instr;

  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  redirect_target;
  logic               redirect;
  logic               accept;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect        = flush & ~if_id_stall;
  assign redirect_target = pc_src ? align_word(pc_decode) : pc_q;
  assign accept          = imem_req & imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ISSUE;
      pc_q           <= RESET_PC;
      target_q       <= '0;
      hold_pc_next_q <= '0;
      hold_instr_q   <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      target_q       <= target_d;
      hold_pc_next_q <= hold_pc_next_d;
      hold_instr_q   <= hold_instr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    target_d       = target_q;
    hold_pc_next_d = hold_pc_next_q;
    hold_instr_d   = hold_instr_q;
    ifid_load      = 1'b0;
    ifid_bubble    = 1'b0;
    ifid_pc_next   = pc_plus4;
    ifid_instr     = imem_rdata;

    unique case (state_q)
      ST_ISSUE, ST_WAIT: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          // A request still pending must keep its address, so drain it first.
          if (imem_req && !imem_ready) begin
            target_d = redirect_target;
            state_d  = ST_DRAIN;
          end else begin
            pc_d    = redirect_target;
            state_d = ST_ISSUE;
          end
        end else if (accept) begin
          if (!if_id_stall) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
            state_d   = ST_ISSUE;
          end else begin
            hold_pc_next_d = pc_plus4;
            hold_instr_d   = imem_rdata;
            state_d        = ST_HOLD;
          end
        end else if (imem_req) begin
          state_d = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          pc_d        = redirect_target;
          state_d     = ST_ISSUE;
        end else if (!if_id_stall) begin
          ifid_load    = 1'b1;
          ifid_pc_next = hold_pc_next_q;
          ifid_instr   = hold_instr_q;
          pc_d         = pc_plus4;
          state_d      = ST_ISSUE;
        end
      end

      ST_DRAIN: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          target_d    = redirect_target;
        end
        if (imem_ready) begin
          pc_d    = redirect ? redirect_target : target_q;
          state_d = ST_ISSUE;
        end
      end

      default: state_d = ST_ISSUE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    fetch_busy = 1'b0;
    unique case (state_q)
      ST_ISSUE: imem_req = ~pc_stall & ~reset;
      ST_WAIT, ST_DRAIN: begin
        imem_req   = 1'b1;
        fetch_busy = 1'b1;
      end
      ST_HOLD:  fetch_busy = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .load_i        (ifid_load),
    .bubble_i      (ifid_bubble),
    .pc_next_i     (ifid_pc_next),
    .instruction_i (ifid_instr),
    .pc_next_o     (if_id_pc_next),
    .instruction_o (if_id_instruction),
    .valid_o       (if_id_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_stage: directed vectors with hand-computed expectations for the   |
// | fetch stage.                                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        pc_stall;
  logic        if_id_stall;
  logic        flush;
  logic        pc_src;
  logic [31:0] pc_decode;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        fetch_busy;

  int n_tests;
  int n_fail;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pc_stall          (pc_stall),
    .if_id_stall       (if_id_stall),
    .flush             (flush),
    .pc_src            (pc_src),
    .pc_decode         (pc_decode),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .imem_ready        (imem_ready),
    .if_id_pc_next     (if_id_pc_next),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .fetch_busy        (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pcn,
                            input logic [31:0] ins, input logic v);
    check({tag, ".pc_next"}, if_id_pc_next, pcn);
    check({tag, ".instr"}, if_id_instruction, ins);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    flush       = 1'b0;
    pc_src      = 1'b0;
    pc_decode   = 32'h0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b0;

    // Reset state
    step();
    step();
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.busy", {31'd0, fetch_busy}, 32'd0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);

    // 1: zero-wait streaming
    reset = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    #1;
    check("t1.req0", {31'd0, imem_req}, 32'd1);
    check("t1.addr0", imem_addr, 32'h0);
    step();
    check_ifid("t1.a", 32'h4, 32'h2008_0005, 1'b1);
    check("t1.addr4", imem_addr, 32'h4);
    imem_rdata = 32'h2009_0003;
    step();
    check_ifid("t1.b", 32'h8, 32'h2009_0003, 1'b1);
    check("t1.addr8", imem_addr, 32'h8);
    imem_rdata = 32'hAAAA_0008;
    step();
    imem_rdata = 32'hAAAA_000C;
    step();
    check("t1.addr10", imem_addr, 32'h10);

    // 2: three wait cycles at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2.req", {31'd0, imem_req}, 32'd1);
      check("t2.addr", imem_addr, 32'h10);
      check("t2.ifid_held", if_id_pc_next, 32'h10);
      step();
      check("t2.busy", {31'd0, fetch_busy}, 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h8C0A_0000;
    step();
    check_ifid("t2", 32'h14, 32'h8C0A_0000, 1'b1);
    check("t2.busy_end", {31'd0, fetch_busy}, 32'd0);

    // 3: word arrives under stall, parked in HOLD
    imem_ready = 1'b0;
    step();
    check("t3.wait", {31'd0, fetch_busy}, 32'd1);
    pc_stall = 1'b1;
    if_id_stall = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h0123_4567;
    step();
    imem_ready = 1'b0;
    #1;
    check("t3.req_hold", {31'd0, imem_req}, 32'd0);
    check("t3.busy_hold", {31'd0, fetch_busy}, 32'd1);
    check_ifid("t3.hold1", 32'h14, 32'h8C0A_0000, 1'b1);
    step();
    check_ifid("t3.hold2", 32'h14, 32'h8C0A_0000, 1'b1);
    check("t3.addr_hold", imem_addr, 32'h14);
    pc_stall = 1'b0;
    if_id_stall = 1'b0;
    step();
    check_ifid("t3.rel", 32'h18, 32'h0123_4567, 1'b1);
    check("t3.addr_rel", imem_addr, 32'h18);

    // 4: redirect while waiting at 0x20
    imem_ready = 1'b1;
    imem_rdata = 32'hBBBB_0018;
    step();
    imem_rdata = 32'hBBBB_001C;
    step();
    check("t4.addr20", imem_addr, 32'h20);
    imem_ready = 1'b0;
    step();
    flush = 1'b1;
    pc_src = 1'b1;
    pc_decode = 32'h0000_0043;
    step();
    flush = 1'b0;
    pc_src = 1'b0;
    check_ifid("t4.bubble", 32'h0, 32'h0, 1'b0);
    check("t4.drain_addr", imem_addr, 32'h20);
    check("t4.drain_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    check("t4.addr40", imem_addr, 32'h40);
    check("t4.dropped", {31'd0, if_id_valid}, 32'd0);
    imem_rdata = 32'h1111_1111;
    step();
    check_ifid("t4.new", 32'h44, 32'h1111_1111, 1'b1);

    // 5: flush masked by if_id_stall
    pc_stall = 1'b1;
    if_id_stall = 1'b1;
    flush = 1'b1;
    pc_src = 1'b1;
    pc_decode = 32'h80;
    step();
    check_ifid("t5", 32'h44, 32'h1111_1111, 1'b1);
    check("t5.addr", imem_addr, 32'h44);
    if_id_stall = 1'b0;
    flush = 1'b0;
    pc_src = 1'b0;

    // Redirect with no request in flight, then pc+4 wraps
    flush = 1'b1;
    pc_src = 1'b1;
    pc_decode = 32'hFFFF_FFFE;
    step();
    flush = 1'b0;
    pc_src = 1'b0;
    pc_stall = 1'b0;
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    check_ifid("wrap.bubble", 32'h0, 32'h0, 1'b0);
    imem_rdata = 32'h2222_2222;
    step();
    check_ifid("wrap", 32'h0, 32'h2222_2222, 1'b1);
    check("wrap.addr0", imem_addr, 32'h0);

    // 6: reset during WAIT
    imem_ready = 1'b0;
    step();
    check("t6.wait", {31'd0, fetch_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6.req_drop", {31'd0, imem_req}, 32'd0);
    check("t6.valid_rst", {31'd0, if_id_valid}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("t6.addr", imem_addr, 32'h0);
    check("t6.req", {31'd0, imem_req}, 32'd1);
    step();
    check("t6.valid_pre", {31'd0, if_id_valid}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'h3333_3333;
    step();
    check_ifid("t6.first", 32'h4, 32'h3333_3333, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
